// File: rtl/cnn_window_gen.sv
// cnn_window_gen: turns a raster pixel stream into zero-padded 3x3 windows, one per pixel.
`ifndef WIDTH
`define WIDTH 16
`endif
module cnn_window_gen #(
  parameter int IMG_W = 4,
  parameter int IMG_H = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [`WIDTH-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [`WIDTH-1:0] W1,
  output logic signed [`WIDTH-1:0] W2,
  output logic signed [`WIDTH-1:0] W3,
  output logic signed [`WIDTH-1:0] W4,
  output logic signed [`WIDTH-1:0] W5,
  output logic signed [`WIDTH-1:0] W6,
  output logic signed [`WIDTH-1:0] W7,
  output logic signed [`WIDTH-1:0] W8,
  output logic signed [`WIDTH-1:0] W9,
  output logic                     out_last
);
  localparam int D  = 2*IMG_W+3;
  localparam int N  = IMG_W*IMG_H;
  localparam int KW = $clog2(N+1);
  localparam int FW = $clog2(IMG_W+2);
  localparam int CW = $clog2(IMG_W+1);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t r_state, w_state_nx;
  logic signed [`WIDTH-1:0] r_sr [D];
  logic signed [`WIDTH-1:0] w_sh [D];
  logic signed [`WIDTH-1:0] r_w [9];
  logic signed [`WIDTH-1:0] w_win [9];
  logic [KW-1:0] r_k;
  logic [FW-1:0] r_f;
  logic [CW-1:0] r_c;
  logic r_valid, r_last, w_free, w_shift, w_load, w_done;
  assign w_free = !r_valid || out_ready;
  always_comb begin
    w_shift    = (r_state == RUN) ? in_valid && w_free : w_free;
    w_load     = (r_state == RUN) ? w_shift && (r_k >= KW'(IMG_W+1)) : w_free;
    w_done     = (r_state == FLUSH) && w_free && (r_f == FW'(IMG_W));
    in_ready   = (r_state == RUN) && w_free;
    w_state_nx = r_state;
    if (r_state == RUN && w_shift && r_k == KW'(N-1))
      w_state_nx = FLUSH;
    if (w_done)
      w_state_nx = RUN;
  end
  // The window is cut from the post-shift view so it loads in the same cycle as the shift.
  always_comb begin
    w_sh[0] = (r_state == RUN) ? in_data : '0;
    for (int i = 1; i < D; i++)
      w_sh[i] = r_sr[i-1];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w_win[3*i+j] = ((j == 0 && r_c == '0) || (j == 2 && r_c == CW'(IMG_W-1))) ? '0 : w_sh[(2-i)*IMG_W+2-j];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_sr    <= '{default: '0};
      r_w     <= '{default: '0};
      r_k     <= '0;
      r_f     <= '0;
      r_c     <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_shift)
        r_sr <= w_sh;
      if (r_state == RUN && w_shift)
        r_k <= r_k + 1'b1;
      if (r_state == FLUSH && w_free)
        r_f <= r_f + 1'b1;
      if (w_done) begin
        r_sr <= '{default: '0};
        r_k  <= '0;
        r_f  <= '0;
      end
      if (w_load) begin
        r_w     <= w_win;
        r_valid <= 1'b1;
        r_last  <= w_done;
        r_c     <= (r_c == CW'(IMG_W-1)) ? '0 : r_c + 1'b1;
      end else if (w_free) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end
    end
  end
  assign out_valid = r_valid;
  assign out_last  = r_last;
  assign W1 = r_w[0];
  assign W2 = r_w[1];
  assign W3 = r_w[2];
  assign W4 = r_w[3];
  assign W5 = r_w[4];
  assign W6 = r_w[5];
  assign W7 = r_w[6];
  assign W8 = r_w[7];
  assign W9 = r_w[8];
endmodule

// File: tb/tb_cnn_window_gen.sv
// tb_cnn_window_gen: randomized stream checks of cnn_window_gen against a padded-image window model.
`ifndef WIDTH
`define WIDTH 16
`endif
module tb_cnn_window_gen;
  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W*H;
  typedef int win_t [9];
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0, in_ready, out_valid, out_last;
  logic signed [`WIDTH-1:0] in_data = '0;
  logic signed [`WIDTH-1:0] wo [9];
  logic in_valid3 = 1'b0, out_ready3 = 1'b0, in_ready3, out_valid3, out_last3;
  logic signed [`WIDTH-1:0] in_data3 = '0;
  logic signed [`WIDTH-1:0] wo3 [9];
  int checks = 0, errors = 0;
  win_t cap[$];
  int cap_last[$];
  int fw, fa;
  always #5 clk = ~clk;

  cnn_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .W1(wo[0]), .W2(wo[1]), .W3(wo[2]), .W4(wo[3]), .W5(wo[4]), .W6(wo[5]), .W7(wo[6]), .W8(wo[7]), .W9(wo[8]),
    .out_last(out_last));

  cnn_window_gen #(.IMG_W(3), .IMG_H(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
    .out_valid(out_valid3), .out_ready(out_ready3),
    .W1(wo3[0]), .W2(wo3[1]), .W3(wo3[2]), .W4(wo3[3]), .W5(wo3[4]), .W6(wo3[5]), .W7(wo3[6]), .W8(wo3[7]), .W9(wo3[8]),
    .out_last(out_last3));

  function automatic int ref_px(input int pix[$], input int base, input int r, input int c);
    return (r < 0 || r >= H || c < 0 || c >= W) ? 0 : pix[base + r*W + c];
  endfunction

  function automatic win_t ref_win(input int pix[$], input int n);
    win_t e;
    int base = (n / N) * N;
    int p = n % N;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        e[3*i+j] = ref_px(pix, base, p/W + i - 1, p%W + j - 1);
    return e;
  endfunction

  function automatic win_t get_win();
    win_t g;
    for (int i = 0; i < 9; i++)
      g[i] = int'(wo[i]);
    return g;
  endfunction

  task automatic run_stream(input int pix[$], input int pv, input int pr, input int stall_idx);
    int nin = 0, nout = 0, cyc = 0, stall = 0, total;
    win_t e, g;
    total = pix.size();
    fa = -1;
    fw = 0;
    cap.delete();
    cap_last.delete();
    while (nout < total && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (out_valid && fa < 0) fa = nin;
      in_valid = (nin < total) && ($urandom_range(99) < pv);
      in_data = (nin < total) ? `WIDTH'(pix[nin]) : '0;
      out_ready = $urandom_range(99) < pr;
      if (out_valid && nout == stall_idx && stall < 3) begin
        out_ready = 1'b0;
        stall++;
      end
      #1;
      if (out_valid && !out_ready && nout == stall_idx) begin
        e = ref_win(pix, nout);
        g = get_win();
        checks++;
        if (g != e || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall win %0d: got %p in_ready=%b, expected %p in_ready=0", nout, g, in_ready, e);
        end
      end
      if (out_valid && out_ready) begin
        e = ref_win(pix, nout);
        g = get_win();
        checks++;
        if (g != e || out_last !== (nout % N == N-1)) begin
          errors++;
          $display("FAIL win %0d: got %p last=%b, expected %p last=%b", nout, g, out_last, e, (nout % N == N-1));
        end
        cap.push_back(g);
        cap_last.push_back(int'(out_last));
        if (!in_ready) fw++;
        nout++;
      end
      if (in_valid && in_ready) nin++;
    end
    checks++;
    if (nout != total) begin
      errors++;
      $display("FAIL timeout: got %0d windows, expected %0d", nout, total);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset flags: got valid=%b last=%b in_ready=%b, expected 0 0 1", out_valid, out_last, in_ready);
    end
    checks++;
    if (get_win() != '{0,0,0,0,0,0,0,0,0}) begin
      errors++;
      $display("FAIL reset window: got %p, expected all 0", get_win());
    end
    checks++;
    if (out_valid3 !== 1'b0 || in_ready3 !== 1'b1) begin
      errors++;
      $display("FAIL reset3: got valid=%b in_ready=%b, expected 0 1", out_valid3, in_ready3);
    end
    rst = 1'b0;
  endtask

  task automatic check_frame_one(input string tag);
    win_t e00 = '{0,0,0,0,1,2,0,5,6};
    win_t e11 = '{1,2,3,5,6,7,9,10,11};
    win_t e30 = '{0,9,10,0,13,14,0,0,0};
    win_t e33 = '{11,12,0,15,16,0,0,0,0};
    checks++;
    if (fa != 6) begin
      errors++;
      $display("FAIL %s first_valid: got after %0d accepts, expected 6", tag, fa);
    end
    checks++;
    if (cap.size() != 16) begin
      errors++;
      $display("FAIL %s count: got %0d, expected 16", tag, cap.size());
    end else begin
      checks++;
      if (cap[0] != e00 || cap[5] != e11) begin
        errors++;
        $display("FAIL %s early: got %p %p, expected %p %p", tag, cap[0], cap[5], e00, e11);
      end
      checks++;
      if (cap[12] != e30 || cap[15] != e33 || cap_last[15] != 1 || cap_last[14] != 0) begin
        errors++;
        $display("FAIL %s late: got %p %p last=%0d, expected %p %p last=1", tag, cap[12], cap[15], cap_last[15], e30, e33);
      end
    end
  endtask

  task automatic test_basic();
    int p[$];
    for (int i = 1; i <= 16; i++) p.push_back(i);
    run_stream(p, 100, 100, -1);
    check_frame_one("basic");
    checks++;
    if (fw != 5) begin
      errors++;
      $display("FAIL flush_windows: got %0d, expected 5", fw);
    end
  endtask

  task automatic test_backpressure();
    int p[$];
    for (int i = 1; i <= 16; i++) p.push_back(i);
    run_stream(p, 100, 100, 6);
    checks++;
    if (cap.size() != 16 || cap[6] != '{2,3,4,6,7,8,10,11,12}) begin
      errors++;
      $display("FAIL backpressure: got %0d windows, win6 %p, expected 16 and '{2,3,4,6,7,8,10,11,12}", cap.size(), cap[6]);
    end
  endtask

  task automatic test_back_to_back();
    int p[$];
    for (int i = 1; i <= 16; i++) p.push_back(i);
    for (int i = 101; i <= 116; i++) p.push_back(i);
    run_stream(p, 100, 100, -1);
    checks++;
    if (cap.size() != 32 || cap[16] != '{0,0,0,0,101,102,0,105,106} || cap_last[31] != 1) begin
      errors++;
      $display("FAIL back_to_back: got %0d windows, win16 %p, expected 32 and '{0,0,0,0,101,102,0,105,106}", cap.size(), cap[16]);
    end
  endtask

  task automatic test_reset_mid();
    int p[$];
    int n = 0, cyc = 0;
    out_ready = 1'b1;
    while (n < 7 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      in_valid = 1'b1;
      in_data = `WIDTH'(n + 1);
      #1;
      if (in_ready) n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || get_win() != '{0,0,0,0,0,0,0,0,0}) begin
      errors++;
      $display("FAIL reset_mid: got valid=%b in_ready=%b win %p, expected 0 1 zeros", out_valid, in_ready, get_win());
    end
    rst = 1'b0;
    out_ready = 1'b0;
    for (int i = 1; i <= 16; i++) p.push_back(i);
    run_stream(p, 100, 100, -1);
    check_frame_one("reset_mid");
  endtask

  task automatic test_random();
    int p[$];
    for (int i = 0; i < 3*N; i++) p.push_back(int'($urandom_range(2000)) - 1000);
    run_stream(p, 70, 60, -1);
    checks++;
    if (cap.size() != 3*N) begin
      errors++;
      $display("FAIL random count: got %0d, expected %0d", cap.size(), 3*N);
    end
    p.delete();
    for (int i = 0; i < 2*N; i++) p.push_back(int'($urandom_range(60000)) - 30000);
    run_stream(p, 40, 90, -1);
  endtask

  task automatic test_signed3();
    int c3 [9][9];
    int l3 [9];
    int n = 0, got = 0, cyc = 0, neg, zer;
    while (got < 9 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      in_valid3 = n < 9;
      in_data3 = `WIDTH'(-5);
      out_ready3 = 1'b1;
      #1;
      if (out_valid3 && out_ready3) begin
        for (int k = 0; k < 9; k++) c3[got][k] = int'(wo3[k]);
        l3[got] = int'(out_last3);
        got++;
      end
      if (in_valid3 && in_ready3) n++;
    end
    @(negedge clk);
    in_valid3 = 1'b0;
    checks++;
    if (got != 9) begin
      errors++;
      $display("FAIL signed3 count: got %0d, expected 9", got);
    end else begin
      neg = 0;
      for (int k = 0; k < 9; k++) if (c3[4][k] == -5) neg++;
      checks++;
      if (neg != 9) begin
        errors++;
        $display("FAIL signed3 centre: got %0d of -5, expected 9", neg);
      end
      for (int q = 0; q < 9; q += 2) begin
        if (q == 4) continue;
        neg = 0;
        zer = 0;
        for (int k = 0; k < 9; k++) begin
          if (c3[q][k] == -5) neg++;
          if (c3[q][k] == 0) zer++;
        end
        checks++;
        if (neg != 4 || zer != 5) begin
          errors++;
          $display("FAIL signed3 corner %0d: got %0d neg %0d zero, expected 4 5", q, neg, zer);
        end
      end
      checks++;
      if (l3[8] != 1 || l3[7] != 0) begin
        errors++;
        $display("FAIL signed3 last: got %0d %0d, expected 0 1", l3[7], l3[8]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_signed3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
